// File: rtl/aes_ctr_stream_arbiter.sv
// aes_ctr_stream_arbiter: shares one iterative AES-256-CTR core between NUM_CH
// AXI-Stream requesters, one packet at a time in round-robin order. The core's
// output stream is routed back to the channel that owns the core.
// Optional feature: define AES_ARB_PKTCNT_EN to add the per-channel 16-bit
// Pkt_cnt output (completed output packets per channel).
module aes_ctr_stream_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned BLOCK_SIZE = 128
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic [NUM_CH-1:0]                  S_axis_tvalid,
  output logic [NUM_CH-1:0]                  S_axis_tready,
  input  logic [NUM_CH*BLOCK_SIZE-1:0]       S_axis_tdata,
  input  logic [NUM_CH*(BLOCK_SIZE/8)-1:0]   S_axis_tkeep,
  input  logic [NUM_CH-1:0]                  S_axis_tlast,
  input  logic [NUM_CH-1:0]                  S_axis_tuser,
  output logic [NUM_CH-1:0]                  M_axis_tvalid,
  input  logic [NUM_CH-1:0]                  M_axis_tready,
  output logic [NUM_CH*BLOCK_SIZE-1:0]       M_axis_tdata,
  output logic [NUM_CH*(BLOCK_SIZE/8)-1:0]   M_axis_tkeep,
  output logic [NUM_CH-1:0]                  M_axis_tlast,
  output logic                               Core_s_tvalid,
  input  logic                               Core_s_tready,
  output logic [BLOCK_SIZE-1:0]              Core_s_tdata,
  output logic [BLOCK_SIZE/8-1:0]            Core_s_tkeep,
  output logic                               Core_s_tlast,
  output logic                               Core_s_tuser,
  input  logic                               Core_m_tvalid,
  output logic                               Core_m_tready,
  input  logic [BLOCK_SIZE-1:0]              Core_m_tdata,
  input  logic [BLOCK_SIZE/8-1:0]            Core_m_tkeep,
  input  logic                               Core_m_tlast,
`ifdef AES_ARB_PKTCNT_EN
  output logic [NUM_CH*16-1:0]               Pkt_cnt,
`endif
  output logic                               Grant_valid,
  output logic [$clog2(NUM_CH)-1:0]          Grant_id
);

  localparam int unsigned KEEP_W = BLOCK_SIZE / 8;
  localparam int unsigned ID_W   = $clog2(NUM_CH);
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [0:0] {ST_IDLE, ST_BUSY} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic            grant_valid_q, grant_valid_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            in_done_q, in_done_d;

  logic            req_found;
  logic [ID_W-1:0] req_id;
  int unsigned     gsel;
  logic            in_hs_last;
  logic            out_hs_last;

  assign gsel        = 32'(grant_q);
  assign in_hs_last  = (state_q == ST_BUSY) & Core_s_tvalid & Core_s_tready & Core_s_tlast;
  assign out_hs_last = (state_q == ST_BUSY) & Core_m_tvalid & Core_m_tready & Core_m_tlast;
  assign Grant_valid = grant_valid_q;
  assign Grant_id    = grant_q;

  // Round-robin search: first requesting channel at or above rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    req_found = 1'b0;
    req_id    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!req_found && S_axis_tvalid[ID_W'(idx)]) begin
        req_found = 1'b1;
        req_id    = ID_W'(idx);
      end
    end
  end

  // State and grant registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
      in_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      in_done_q     <= in_done_d;
    end
  end

  // Next-state: grant on any request, release on the core's final output beat.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    rr_ptr_d      = rr_ptr_q;
    in_done_d     = in_done_q;
    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          state_d       = ST_BUSY;
          grant_d       = req_id;
          grant_valid_d = 1'b1;
          in_done_d     = 1'b0;
        end
      end
      ST_BUSY: begin
        if (in_hs_last) in_done_d = 1'b1;
        if (out_hs_last) begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          in_done_d     = 1'b0;
          rr_ptr_d      = (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + ID_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero-latency routing between the granted channel and the core; all else quiet.
  always_comb begin
    S_axis_tready = '0;
    M_axis_tvalid = '0;
    M_axis_tdata  = '0;
    M_axis_tkeep  = '0;
    M_axis_tlast  = '0;
    Core_s_tvalid = 1'b0;
    Core_s_tdata  = '0;
    Core_s_tkeep  = '0;
    Core_s_tlast  = 1'b0;
    Core_s_tuser  = 1'b0;
    Core_m_tready = 1'b0;
    if (state_q == ST_BUSY) begin
      Core_s_tvalid                               = S_axis_tvalid[grant_q] & ~in_done_q;
      Core_s_tdata                                = S_axis_tdata[gsel*BLOCK_SIZE +: BLOCK_SIZE];
      Core_s_tkeep                                = S_axis_tkeep[gsel*KEEP_W +: KEEP_W];
      Core_s_tlast                                = S_axis_tlast[grant_q];
      Core_s_tuser                                = S_axis_tuser[grant_q];
      S_axis_tready[grant_q]                      = Core_s_tready & ~in_done_q;
      M_axis_tvalid[grant_q]                      = Core_m_tvalid;
      M_axis_tdata[gsel*BLOCK_SIZE +: BLOCK_SIZE] = Core_m_tdata;
      M_axis_tkeep[gsel*KEEP_W +: KEEP_W]         = Core_m_tkeep;
      M_axis_tlast[grant_q]                       = Core_m_tlast;
      Core_m_tready                               = M_axis_tready[grant_q];
    end
  end

`ifdef AES_ARB_PKTCNT_EN
  logic [NUM_CH*CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  // Per-channel completed-packet counters, wrapping at 16 bits.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (out_hs_last) pkt_cnt_d[gsel*CNT_W +: CNT_W] = pkt_cnt_q[gsel*CNT_W +: CNT_W] + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge Clk) begin
    if (Rst) pkt_cnt_q <= '0;
    else     pkt_cnt_q <= pkt_cnt_d;
  end

  assign Pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_aes_ctr_stream_arbiter.sv
// Bench for aes_ctr_stream_arbiter: queued per-channel sources, a stand-in core
// model (keystream XOR), and per-channel expected-output scoreboards.
module tb_aes_ctr_stream_arbiter;

  localparam int unsigned NCH = 4;
  localparam int unsigned BS  = 128;
  localparam int unsigned KW  = 16;
  localparam int unsigned IDW = 2;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic         user;
  } beat_t;

  typedef struct {
    int           ch;
    logic [127:0] klo;
    logic [127:0] khi;
    logic [127:0] ctr;
    logic [127:0] d0;
    int           n;
    logic         user;
    int           exp_grant;
    int           exp_beats;
  } vec_t;

  logic                Clk, Rst;
  logic [NCH-1:0]      s_tvalid, S_axis_tready, s_tlast, s_tuser;
  logic [NCH*BS-1:0]   s_tdata;
  logic [NCH*KW-1:0]   s_tkeep;
  logic [NCH-1:0]      M_axis_tvalid, m_rdy, M_axis_tlast;
  logic [NCH*BS-1:0]   M_axis_tdata;
  logic [NCH*KW-1:0]   M_axis_tkeep;
  logic                Core_s_tvalid, core_s_rdy, Core_s_tlast, Core_s_tuser;
  logic [BS-1:0]       Core_s_tdata;
  logic [KW-1:0]       Core_s_tkeep;
  logic                cm_valid, Core_m_tready, cm_last;
  logic [BS-1:0]       cm_data;
  logic [KW-1:0]       cm_keep;
  logic                Grant_valid;
  logic [IDW-1:0]      Grant_id;
`ifdef AES_ARB_PKTCNT_EN
  logic [NCH*16-1:0]   Pkt_cnt;
`endif

  aes_ctr_stream_arbiter #(.NUM_CH(NCH), .BLOCK_SIZE(BS)) dut (
    .Clk(Clk), .Rst(Rst),
    .S_axis_tvalid(s_tvalid), .S_axis_tready(S_axis_tready), .S_axis_tdata(s_tdata),
    .S_axis_tkeep(s_tkeep), .S_axis_tlast(s_tlast), .S_axis_tuser(s_tuser),
    .M_axis_tvalid(M_axis_tvalid), .M_axis_tready(m_rdy), .M_axis_tdata(M_axis_tdata),
    .M_axis_tkeep(M_axis_tkeep), .M_axis_tlast(M_axis_tlast),
    .Core_s_tvalid(Core_s_tvalid), .Core_s_tready(core_s_rdy), .Core_s_tdata(Core_s_tdata),
    .Core_s_tkeep(Core_s_tkeep), .Core_s_tlast(Core_s_tlast), .Core_s_tuser(Core_s_tuser),
    .Core_m_tvalid(cm_valid), .Core_m_tready(Core_m_tready), .Core_m_tdata(cm_data),
    .Core_m_tkeep(cm_keep), .Core_m_tlast(cm_last),
`ifdef AES_ARB_PKTCNT_EN
    .Pkt_cnt(Pkt_cnt),
`endif
    .Grant_valid(Grant_valid), .Grant_id(Grant_id)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  beat_t        src_q [NCH][$];
  beat_t        exp_q [NCH][$];
  beat_t        core_q[$];
  int           grant_log[$];
  int           mout_cnt [NCH];
  int           last_cyc [NCH];
  int           cyc;
  int           n_chk, n_fail;
  int           c_stage;
  logic [127:0] c_klo, c_khi, c_ctr;
  logic         rnd_core;
  logic         gv_prev;

  // Stand-in keystream; user=0 (decrypt) inverts it so the tuser path is visible.
  function automatic logic [127:0] ks(input logic [127:0] klo, input logic [127:0] khi,
                                      input logic [127:0] ctr, input int idx, input logic user);
    logic [127:0] r;
    r = klo ^ {khi[63:0], khi[127:64]} ^ (ctr + 128'(idx));
    if (!user) r = ~r;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flush_all();
    for (int ch = 0; ch < NCH; ch++) begin
      src_q[ch].delete();
      exp_q[ch].delete();
    end
    core_q.delete();
    c_stage = 0;
  endtask

  function automatic bit all_empty();
    bit e;
    e = (core_q.size() == 0);
    for (int ch = 0; ch < NCH; ch++)
      if (src_q[ch].size() != 0 || exp_q[ch].size() != 0) e = 0;
    return e;
  endfunction

  // Queue one packet on a channel and its expected output beats on the scoreboard.
  task automatic push_pkt(input int ch, input logic [127:0] klo, input logic [127:0] khi,
                          input logic [127:0] ctr, input logic [127:0] d0, input int n,
                          input logic user);
    beat_t b, e;
    b.keep = '1; b.last = 1'b0; b.user = user;
    b.data = klo; src_q[ch].push_back(b);
    b.data = khi; src_q[ch].push_back(b);
    b.data = ctr; src_q[ch].push_back(b);
    for (int i = 0; i < n; i++) begin
      b.data = d0 + 128'(i);
      b.last = (i == n - 1);
      b.keep = (i == n - 1) ? 16'h0FFF : 16'hFFFF;
      src_q[ch].push_back(b);
      e      = b;
      e.user = 1'b0;
      e.data = b.data ^ ks(klo, khi, ctr, i, user);
      exp_q[ch].push_back(e);
    end
  endtask

  // Drive sources/core at negedge, then account for the handshakes of the coming posedge.
  initial begin : engine
    beat_t b;
    logic  quiet;
    cyc = 0; c_stage = 0; gv_prev = 1'b0;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
    core_s_rdy = 1'b1; cm_valid = 1'b0; cm_data = '0; cm_keep = '0; cm_last = 1'b0;
    forever begin
      @(negedge Clk);
      for (int ch = 0; ch < NCH; ch++) begin
        if (src_q[ch].size() > 0) begin b = src_q[ch][0]; s_tvalid[ch] = 1'b1; end
        else begin b = '0; s_tvalid[ch] = 1'b0; end
        s_tdata[ch*BS +: BS] = b.data;
        s_tkeep[ch*KW +: KW] = b.keep;
        s_tlast[ch]          = b.last;
        s_tuser[ch]          = b.user;
      end
      core_s_rdy = rnd_core ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (core_q.size() > 0) begin b = core_q[0]; cm_valid = 1'b1; end
      else begin b = '0; cm_valid = 1'b0; end
      cm_data = b.data; cm_keep = b.keep; cm_last = b.last;
      #1;
      cyc++;
      if (Rst) begin
        flush_all();
        gv_prev = 1'b0;
      end else begin
        for (int ch = 0; ch < NCH; ch++)
          if (s_tvalid[ch] && S_axis_tready[ch]) void'(src_q[ch].pop_front());
        if (Core_s_tvalid && core_s_rdy) begin
          case (c_stage)
            0: c_klo = Core_s_tdata;
            1: c_khi = Core_s_tdata;
            2: c_ctr = Core_s_tdata;
            default: begin
              b.data = Core_s_tdata ^ ks(c_klo, c_khi, c_ctr, c_stage - 3, Core_s_tuser);
              b.keep = Core_s_tkeep; b.last = Core_s_tlast; b.user = 1'b0;
              core_q.push_back(b);
            end
          endcase
          c_stage = (c_stage >= 3 && Core_s_tlast) ? 0 : c_stage + 1;
        end
        if (cm_valid && Core_m_tready) void'(core_q.pop_front());
        quiet = 1'b1;
        for (int ch = 0; ch < NCH; ch++)
          if (!(Grant_valid && int'(Grant_id) == ch))
            if (M_axis_tvalid[ch] || S_axis_tready[ch] || M_axis_tdata[ch*BS +: BS] != '0) quiet = 1'b0;
        if (!Grant_valid && Grant_id != '0) quiet = 1'b0;
        chk("nongranted_quiet", 128'(quiet), 128'(1));
        for (int ch = 0; ch < NCH; ch++) begin
          if (M_axis_tvalid[ch] && m_rdy[ch]) begin
            if (exp_q[ch].size() == 0) begin
              chk($sformatf("unexpected_beat_ch%0d", ch), 128'(1), 128'(0));
            end else begin
              b = exp_q[ch].pop_front();
              chk($sformatf("m_data_ch%0d", ch), M_axis_tdata[ch*BS +: BS], b.data);
              chk($sformatf("m_keep_ch%0d", ch), 128'(M_axis_tkeep[ch*KW +: KW]), 128'(b.keep));
              chk($sformatf("m_last_ch%0d", ch), 128'(M_axis_tlast[ch]), 128'(b.last));
            end
            mout_cnt[ch]++;
            if (M_axis_tlast[ch]) last_cyc[ch] = cyc;
          end
        end
        if (Grant_valid && !gv_prev) grant_log.push_back(int'(Grant_id));
        gv_prev = Grant_valid;
      end
    end
  end

  // Wait for all traffic to drain and the grant to drop; optionally check the owner.
  task automatic wait_idle(input string name, input int exp_grant);
    int  cnt;
    bit  done;
    cnt = 0; done = 0;
    while (!done) begin
      @(negedge Clk); #2;
      if (exp_grant >= 0 && Grant_valid) chk({name, "_grant_id"}, 128'(Grant_id), 128'(exp_grant));
      done = all_empty() && !Grant_valid;
      cnt++;
      if (!done && cnt > 3000) begin
        n_chk++; n_fail++;
        $display("FAIL %s_timeout: got busy expected idle", name);
        flush_all();
        done = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge Clk); Rst = 1'b1;
    @(negedge Clk); #2;
  endtask

  task automatic chk_order(input string name, input int base, input int g0, input int g1);
    if (grant_log.size() < base + 2) chk({name, "_count"}, 128'(grant_log.size()), 128'(base + 2));
    else begin
      chk({name, "_first"}, 128'(grant_log[base]), 128'(g0));
      chk({name, "_second"}, 128'(grant_log[base+1]), 128'(g1));
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : test
    vec_t tbl [5];
    int   base, gb, cnt;
    tbl[0] = '{1, 128'h1f352c073b6108d72d9810a30914dff4, 128'h603deb1015ca71be2b73aef0857d7781,
               128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'h6bc1bee22e409f96e93d7e117393172a, 2, 1'b1, 1, 2};
    tbl[1] = '{0, 128'h00112233445566778899aabbccddeeff, 128'h0f0e0d0c0b0a09080706050403020100,
               128'h00000000000000000000000000000001, 128'hdeadbeef00000000cafef00d12345678, 1, 1'b1, 0, 1};
    tbl[2] = '{3, 128'h1111, 128'h2222, 128'h3333, 128'hA5A5A5A5, 5, 1'b0, 3, 5};
    tbl[3] = '{2, 128'hffffffffffffffffffffffffffffffff, 128'h0, 128'hfffffffffffffffffffffffffffffffe,
               128'h0, 3, 1'b1, 2, 3};
    tbl[4] = '{1, 128'h5a, 128'ha5, 128'h77, 128'h99, 1, 1'b0, 1, 1};

    n_chk = 0; n_fail = 0; rnd_core = 1'b0; m_rdy = '1; Rst = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin mout_cnt[ch] = 0; last_cyc[ch] = 0; end

    // Reset state.
    @(negedge Clk); #2;
    chk("rst_s_tready", 128'(S_axis_tready), 128'(0));
    chk("rst_m_tvalid", 128'(M_axis_tvalid), 128'(0));
    chk("rst_m_tdata", M_axis_tdata[127:0], 128'(0));
    chk("rst_core_s_tvalid", 128'(Core_s_tvalid), 128'(0));
    chk("rst_core_m_tready", 128'(Core_m_tready), 128'(0));
    chk("rst_grant_valid", 128'(Grant_valid), 128'(0));
    chk("rst_grant_id", 128'(Grant_id), 128'(0));
    @(negedge Clk); Rst = 1'b0;

    // Single-channel packets from the table, random core input back-pressure.
    rnd_core = 1'b1;
    for (int i = 0; i < 5; i++) begin
      base = mout_cnt[tbl[i].ch];
      gb   = grant_log.size();
      push_pkt(tbl[i].ch, tbl[i].klo, tbl[i].khi, tbl[i].ctr, tbl[i].d0, tbl[i].n, tbl[i].user);
      wait_idle($sformatf("vec%0d", i), tbl[i].exp_grant);
      chk($sformatf("vec%0d_beats", i), 128'(mout_cnt[tbl[i].ch] - base), 128'(tbl[i].exp_beats));
      if (grant_log.size() <= gb) chk($sformatf("vec%0d_granted", i), 128'(0), 128'(1));
      else chk($sformatf("vec%0d_grant_log", i), 128'(grant_log[gb]), 128'(tbl[i].exp_grant));
    end

    // Simultaneous ch0/ch2 from rr_ptr=0, ch0 re-requesting: 0, 2, 0.
    do_reset(); Rst = 1'b0;
    gb = grant_log.size();
    push_pkt(0, 128'h10, 128'h20, 128'h30, 128'h40, 2, 1'b1);
    push_pkt(0, 128'h11, 128'h21, 128'h31, 128'h41, 1, 1'b1);
    push_pkt(2, 128'h12, 128'h22, 128'h32, 128'h42, 2, 1'b0);
    wait_idle("rr", -1);
    chk_order("rr_a", gb, 0, 2);
    if (grant_log.size() >= gb + 3) chk("rr_third", 128'(grant_log[gb+2]), 128'(0));
    else chk("rr_third_count", 128'(grant_log.size()), 128'(gb + 3));

    // ch1 held off while ch0 owns the core; released 2 cycles after ch0's final beat.
    rnd_core = 1'b0;
    gb = grant_log.size();
    push_pkt(0, 128'h50, 128'h60, 128'h70, 128'h80, 4, 1'b1);
    cnt = 0;
    do begin @(negedge Clk); #2; cnt++; end while (!(Grant_valid && Grant_id == 2'd0) && cnt < 200);
    push_pkt(1, 128'h51, 128'h61, 128'h71, 128'h81, 1, 1'b1);
    cnt = 0;
    while (cnt < 500) begin
      @(negedge Clk); #2; cnt++;
      if (Grant_valid && Grant_id == 2'd0) chk("hold_ch1_tready", 128'(S_axis_tready[1]), 128'(0));
      else if (S_axis_tready[1]) begin
        chk("hold_release_latency", 128'(cyc - last_cyc[0]), 128'(2));
        cnt = 1000;
      end
    end
    if (cnt < 1000) chk("hold_release_seen", 128'(0), 128'(1));
    wait_idle("hold", -1);
    chk_order("hold_order", gb, 0, 1);

    // Output back-pressure on ch3 for 5 cycles mid-packet.
    push_pkt(3, 128'h90, 128'ha0, 128'hb0, 128'hc0, 6, 1'b0);
    cnt = 0;
    do begin @(negedge Clk); #2; cnt++; end while (exp_q[3].size() > 4 && cnt < 200);
    @(negedge Clk); m_rdy[3] = 1'b0;
    repeat (5) begin
      #2;
      chk("stall_core_m_tready", 128'(Core_m_tready), 128'(0));
      chk("stall_grant", 128'({Grant_valid, Grant_id}), 128'({1'b1, 2'd3}));
      @(negedge Clk);
    end
    m_rdy[3] = 1'b1;
    wait_idle("stall", 3);

    // Reset mid data beat (rr_ptr moved to 2 first), then a fresh round-robin from 0.
    push_pkt(1, 128'h1, 128'h2, 128'h3, 128'h4, 1, 1'b1);
    wait_idle("pre_rst", 1);
    push_pkt(2, 128'hd0, 128'he0, 128'hf0, 128'h100, 4, 1'b1);
    cnt = 0;
    do begin @(negedge Clk); #2; cnt++; end while (src_q[2].size() > 2 && cnt < 200);
    do_reset();
    chk("mid_rst_s_tready", 128'(S_axis_tready), 128'(0));
    chk("mid_rst_m_tvalid", 128'(M_axis_tvalid), 128'(0));
    chk("mid_rst_core_s_tvalid", 128'(Core_s_tvalid), 128'(0));
    chk("mid_rst_core_m_tready", 128'(Core_m_tready), 128'(0));
    chk("mid_rst_grant", 128'({Grant_valid, Grant_id}), 128'(0));
    Rst = 1'b0;
    gb = grant_log.size();
    push_pkt(3, 128'h7, 128'h8, 128'h9, 128'ha, 2, 1'b1);
    push_pkt(0, 128'h3, 128'h4, 128'h5, 128'h6, 2, 1'b0);
    wait_idle("post_rst", -1);
    chk_order("post_rst_order", gb, 0, 3);

`ifdef AES_ARB_PKTCNT_EN
    // Completed-packet counters: 3 on ch0, 1 on ch3.
    begin
      int exp_cnt [NCH];
      exp_cnt = '{3, 0, 0, 1};
      do_reset(); Rst = 1'b0;
      for (int i = 0; i < 3; i++) push_pkt(0, 128'(i), 128'h5, 128'h6, 128'h7, i + 1, 1'b1);
      push_pkt(3, 128'h8, 128'h9, 128'ha, 128'hb, 2, 1'b0);
      wait_idle("pktcnt", -1);
      for (int ch = 0; ch < NCH; ch++)
        chk($sformatf("pktcnt_ch%0d", ch), 128'(Pkt_cnt[ch*16 +: 16]), 128'(exp_cnt[ch]));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
